vga_text_ctrl: RTL
==================

Name: vga_text_ctrl

Overview:
- Text-mode front end for the VGA path. Generates 640x480@60 timing, holds an 80x30 character buffer, and drives the cell indices (h_index, v_index, a_index) into the VGA_char font stage.
- Takes VGA_char's combinational point back and registers the final colour pixel, with sync delayed to match.
- Sits between the host write interface and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- COLS, 80, character columns (H_ACTIVE/8)
- ROWS, 30, character rows (V_ACTIVE/16)
- FG_COLOR, 12'hFFF, colour of lit glyph pixels
- BG_COLOR, 12'h000, colour of unlit active pixels
- SPACE_CODE, 16, glyph code for a blank cell

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  text buffer write strobe
- wr_addr  in  12  cell address = row*COLS + col
- wr_data  in  5  glyph code 0..16
- busy  out  1  high while the post-reset clear runs
- h_index  out  3  pixel column within cell, to VGA_char
- v_index  out  4  pixel row within cell, to VGA_char
- a_index  out  5  glyph code, to VGA_char
- point  in  1  glyph pixel from VGA_char (combinational of the three indices)
- rgb  out  12  {R4,G4,B4} pixel
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync

Behaviour:
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0.
  - Outputs: hsync=1, vsync=1, rgb=0, h_index=0, v_index=0, a_index=SPACE_CODE, busy=1.
  - FSM enters CLEAR; clear_ptr=0.
- Timing counters (stage 0):
  - h_cnt counts 0..799 and wraps to 0; v_cnt increments when h_cnt wraps, counts 0..524 and wraps.
  - de = (h_cnt<640)&&(v_cnt<480).
  - hs_raw low when h_cnt in 656..751; vs_raw low when v_cnt in 490..491.
  - Counters run in both FSM states.
- FSM:
  - CLEAR: writes SPACE_CODE to buffer[clear_ptr], one per cycle. clear_ptr increments; at clear_ptr=COLS*ROWS-1 the FSM moves to RUN on the next edge. Clear lasts 2400 cycles and busy is high throughout.
  - In CLEAR, host wr_en is ignored.
  - RUN: busy=0. The only exit is reset.
- Buffer:
  - 2400 x 5 single-port-write, synchronous-read RAM, inferable as block RAM.
  - Host write occurs when wr_en && wr_addr<2400. Out-of-range writes are dropped silently.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- Stage 1 (registered, 1 cycle after stage 0):
  - Read address = (v_cnt>>4)*COLS + (h_cnt>>3), issued in stage 0; data arrives in stage 1.
  - h_index=h_cnt[2:0], v_index=v_cnt[3:0], delayed one cycle.
  - a_index = SPACE_CODE if !de_d1, or if the read data is >16, or if busy; otherwise the read data.
  - de, hs and vs are delayed to de_d1, hs_d1, vs_d1.
- Stage 2 (registered):
  - rgb = de_d1 ? (point ? FG_COLOR : BG_COLOR) : 0. rgb is forced to 0 while busy.
  - hsync=hs_d1 and vsync=vs_d1 are delayed one more cycle.
  - Total latency from counter to rgb/hsync/vsync is 2 cycles, and sync stays aligned with pixels.
- Reset mid-frame:
  - Counters and pipeline return to reset values immediately.
  - Clear restarts from 0; the buffer is fully re-cleared.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end);
  - COLS, ROWS, CELLS=2400;
  - SPACE_CODE=16;
  - the glyph-code width, 5.
- One sub-module, vga_text_ram: a 2400x5 synchronous-read RAM with read-first behaviour.
- Timing counters and the FSM stay in the top module.
- VGA_char is instantiated by the parent, not inside this block.

Test Plan:
- Reset release:
  - During reset: busy=1, rgb=0, hsync=vsync=1, a_index=16.
  - busy falls exactly 2400 cycles after release.
  - Write attempted during clear at addr 0 -> not stored; cell 0 displays space.
- Sync timing:
  - Over 2 frames, hsync low for 96 cycles starting 2 cycles after h_cnt=656.
  - Line period 800 cycles; vsync low for 2 lines (1600 cycles); frame period 420000 cycles.
- Glyph path:
  - Write code 10 ('A') to addr 0 after clear, with a behavioural VGA_char model on point.
  - Line v_cnt=2 -> rgb=FFF only at h_cnt=4, seen 2 cycles later; BG elsewhere in cells 0..79.
- Addressing:
  - Write code 1 to addr 2399 (row 29, col 79).
  - Line v_cnt=471 -> a_index=1 for h_cnt 632..639, seen one cycle later; 16 elsewhere.
- Bad inputs:
  - wr_addr=2400 with data 3 -> no buffer change.
  - wr_data=20 at addr 5 -> a_index=16 for that cell.
  - Same-cycle read/write to an address being displayed -> old code is shown for that pixel.
- Reset mid-frame at v_cnt=200:
  - Outputs return to reset values asynchronously.
  - busy=1 for 2400 cycles.
  - Previously written cells read back as 16.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing, buffer geometry and glyph-code definitions for the VGA text path.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;

    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BP;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BP;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CODE_W = 5;

    localparam logic [ADDR_W-1:0] COLS  = 12'd80;
    localparam logic [ADDR_W-1:0] ROWS  = 12'd30;
    localparam logic [ADDR_W-1:0] CELLS = COLS * ROWS;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t       SPACE_CODE = 5'd16;
    localparam logic [11:0] FG_COLOR   = 12'hFFF;
    localparam logic [11:0] BG_COLOR   = 12'h000;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // Cell address from the character row (v_cnt>>4) and column (h_cnt>>3).
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        return {6'd0, row} * COLS + {5'd0, col};
    endfunction

endpackage

// File: rtl/vga_text_ctrl_if.sv
// Host write bus into the text buffer, with the clear-in-progress indication.
interface vga_text_ctrl_if;
    import vga_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    code_t             wr_data;
    logic              busy;

    modport master (output wr_en, wr_addr, wr_data, input busy);
    modport slave  (input wr_en, wr_addr, wr_data, output busy);
endinterface

// File: rtl/vga_text_ram.sv
// 2400 x 5 character buffer: one write port, synchronous read-first read port.
module vga_text_ram
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  code_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output code_t             rdata
);

    code_t mem [0:CELLS-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_text_ctrl.sv
// 640x480@60 text-mode front end: timing, 80x30 character buffer with
// post-reset clear, cell indices to the font stage, registered colour and sync.
module vga_text_ctrl
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    vga_text_ctrl_if.slave    host,
    output logic [2:0]        h_index,
    output logic [3:0]        v_index,
    output code_t             a_index,
    input  logic              point,
    output logic [11:0]       rgb,
    output logic              hsync,
    output logic              vsync
);

    logic [9:0]        h_cnt, v_cnt;
    logic              de, hs_raw, vs_raw;
    logic              de_d1, hs_d1, vs_d1;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clear_ptr, clear_ptr_nxt;
    logic              busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr, rd_cell;
    code_t             ram_wdata, ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_TOTAL - 10'd1) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign de     = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign hs_raw = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign vs_raw = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    // The clear owns the write port; host writes are only accepted in RUN.
    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        busy          = 1'b0;
        ram_we        = 1'b0;
        ram_waddr     = host.wr_addr;
        ram_wdata     = host.wr_data;
        case (state)
            ST_CLEAR: begin
                busy          = 1'b1;
                ram_we        = 1'b1;
                ram_waddr     = clear_ptr;
                ram_wdata     = SPACE_CODE;
                clear_ptr_nxt = clear_ptr + 12'd1;
                if (clear_ptr == CELLS - 12'd1)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                ram_we = host.wr_en && (host.wr_addr < CELLS);
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign host.busy = busy;

    // Blanking rows/columns compute addresses past the buffer; fold them onto 0.
    assign rd_cell   = cell_addr(v_cnt[9:4], h_cnt[9:3]);
    assign ram_raddr = (rd_cell < CELLS) ? rd_cell : '0;

    vga_text_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_index <= '0;
            v_index <= '0;
            de_d1   <= 1'b0;
            hs_d1   <= 1'b1;
            vs_d1   <= 1'b1;
        end else begin
            h_index <= h_cnt[2:0];
            v_index <= v_cnt[3:0];
            de_d1   <= de;
            hs_d1   <= hs_raw;
            vs_d1   <= vs_raw;
        end
    end

    // Read data lands in stage 1, so the glyph code is decoded combinationally here.
    assign a_index = (!de_d1 || (ram_rdata > SPACE_CODE) || busy) ? SPACE_CODE : ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= (busy || !de_d1) ? '0 : (point ? FG_COLOR : BG_COLOR);
            hsync <= hs_d1;
            vsync <= vs_d1;
        end
    end

endmodule
